// File: rtl/vga_pkg.sv
// Shared VGA timing presets and the total-period helper used by the raster generator.
package vga_pkg;

    // 640x480@60, 25 MHz pixel derived from a 50 MHz clock
    localparam int unsigned VGA_CLK_DIV  = 2;
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam bit          VGA_HS_POL   = 1'b0;
    localparam bit          VGA_VS_POL   = 1'b0;

    // 800x600@72, 50 MHz pixel straight from the system clock
    localparam int unsigned SVGA_CLK_DIV  = 1;
    localparam int unsigned SVGA_H_ACTIVE = 800;
    localparam int unsigned SVGA_H_FP     = 56;
    localparam int unsigned SVGA_H_SYNC   = 120;
    localparam int unsigned SVGA_H_BP     = 64;
    localparam int unsigned SVGA_V_ACTIVE = 600;
    localparam int unsigned SVGA_V_FP     = 37;
    localparam int unsigned SVGA_V_SYNC   = 6;
    localparam int unsigned SVGA_V_BP     = 23;
    localparam bit          SVGA_HS_POL   = 1'b1;
    localparam bit          SVGA_VS_POL   = 1'b1;

    function automatic int unsigned vga_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_pix_tick.sv
// Pixel-rate divider: o_tick is high while the divider sits on its last count.
module pix_tick #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_q;
    logic [DW-1:0] div_cnt_d;
    logic          tick_q;
    logic          tick_d;

    // tick_q mirrors (div_cnt_q == LAST) without a combinational output path
    always_comb begin
        div_cnt_d = (div_cnt_q == LAST) ? DW'(0) : div_cnt_q + DW'(1);
        tick_d    = (div_cnt_d == LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_cnt_q <= DW'(0);
            tick_q    <= (CLK_DIV == 1);
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
        end
    end

    assign o_tick = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: h/v counters advanced on the pixel tick,
// all outputs registered from next-state decodes so they describe the current (h,v).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter bit          HS_POL   = VGA_HS_POL,
    parameter bit          VS_POL   = VGA_VS_POL,
    localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int unsigned XW      = $clog2(H_TOTAL),
    localparam int unsigned YW      = $clog2(V_TOTAL)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic          o_pix_en,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_blank_n,
    output logic          o_sync_n,
    output logic          o_de,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_line_start,
    output logic          o_frame_start
);

    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam int unsigned   HS_START = H_ACTIVE + H_FP;
    localparam int unsigned   HS_END   = HS_START + H_SYNC;
    localparam int unsigned   VS_START = V_ACTIVE + V_FP;
    localparam int unsigned   VS_END   = VS_START + V_SYNC;

    logic          tick;
    logic [XW-1:0] h_q, h_d;
    logic [YW-1:0] v_q, v_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          de_q, de_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          pix_en_q, pix_en_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    pix_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (tick)
    );

    // Counter advance and decode of the next position; everything holds between ticks
    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        x_d           = x_q;
        y_d           = y_q;
        de_d          = de_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        pix_en_d      = tick;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = XW'(0);
                v_d = (v_q == V_LAST) ? YW'(0) : v_q + YW'(1);
            end else begin
                h_d = h_q + XW'(1);
            end
            x_d           = h_d;
            y_d           = v_d;
            de_d          = (32'(h_d) < H_ACTIVE) && (32'(v_d) < V_ACTIVE);
            hs_d          = ((32'(h_d) >= HS_START) && (32'(h_d) < HS_END)) ? HS_POL : ~HS_POL;
            vs_d          = ((32'(v_d) >= VS_START) && (32'(v_d) < VS_END)) ? VS_POL : ~VS_POL;
            line_start_d  = (h_d == XW'(0));
            frame_start_d = (h_d == XW'(0)) && (v_d == YW'(0));
        end
    end

    // Reset parks the counters on the last position so the first tick lands on (0,0)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            x_q           <= XW'(0);
            y_q           <= YW'(0);
            de_q          <= 1'b0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            pix_en_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            x_q           <= x_d;
            y_q           <= y_d;
            de_q          <= de_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            pix_en_q      <= pix_en_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign o_pix_en      = pix_en_q;
    assign o_hs          = hs_q;
    assign o_vs          = vs_q;
    assign o_blank_n     = de_q;
    assign o_de          = de_q;
    assign o_sync_n      = 1'b0;
    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_line_start  = line_start_q;
    assign o_frame_start = frame_start_q;

endmodule
